// File: rtl/mul_div_unit_if.sv
// Handshake and result bundle between the pipeline control and the multiply/divide unit.
// The master issues operations; the slave (the unit) returns status and HI/LO.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: one bit per clock on operand magnitudes,
// sign fixup in a final FIX cycle, results held in architectural HI/LO registers.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [5:0]       LAST_CNT = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v, input logic en);
        f_neg_w = en ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        f_neg_2w = en ? (~v + ONE_2W) : v;
    endfunction

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_b_zero;
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic [WIDTH-1:0]     r_orig_a;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_rem;
    logic [5:0]           r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dbz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH-1:0]     w_div_diff;
    logic                 w_div_ok;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_hi_fix;
    logic [WIDTH-1:0]     w_lo_fix;

    assign w_a_neg = bus.op[0] & bus.src_a[WIDTH-1];
    assign w_b_neg = bus.op[0] & bus.src_b[WIDTH-1];

    // Multiply step adds the multiplicand into the upper half when the current multiplier bit is set.
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                       + (r_acc[0] ? {1'b0, r_mag_a} : {(WIDTH+1){1'b0}});
    assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_mag_b});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_mag_b;
    assign w_prod      = f_neg_2w(r_acc, r_neg_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_CALC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = ST_FIX;
                end else begin
                    w_state_next = ST_CALC;
                end
            end
            ST_FIX:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Result selection applied at the FIX edge, including the divide-by-zero override.
    always_comb begin
        w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fix = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_b_zero) begin
                w_hi_fix = r_orig_a;
                w_lo_fix = {WIDTH{1'b1}};
            end else begin
                w_hi_fix = f_neg_w(r_rem, r_neg_r);
                w_lo_fix = f_neg_w(r_acc[WIDTH-1:0], r_neg_q);
            end
        end else begin
            w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
            w_lo_fix = w_prod[WIDTH-1:0];
        end
    end

    // Operand capture, iteration datapath and architectural HI/LO update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_mag_a  <= {WIDTH{1'b0}};
            r_mag_b  <= {WIDTH{1'b0}};
            r_orig_a <= {WIDTH{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_rem    <= {WIDTH{1'b0}};
            r_cnt    <= 6'd0;
            r_dbz    <= 1'b0;
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_is_div <= bus.op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_b_zero <= bus.op[1] & (bus.src_b == {WIDTH{1'b0}});
                        r_mag_a  <= f_neg_w(bus.src_a, w_a_neg);
                        r_mag_b  <= f_neg_w(bus.src_b, w_b_neg);
                        r_orig_a <= bus.src_a;
                        // Low half seeds the multiplier (multiply) or the dividend (divide).
                        r_acc    <= {{WIDTH{1'b0}}, bus.op[1] ? f_neg_w(bus.src_a, w_a_neg)
                                                              : f_neg_w(bus.src_b, w_b_neg)};
                        r_rem    <= {WIDTH{1'b0}};
                        r_cnt    <= 6'd0;
                        r_dbz    <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_is_div) begin
                        r_rem <= w_div_ok ? w_div_diff : w_div_shift[WIDTH-1:0];
                        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_div_ok};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    r_hi  <= w_hi_fix;
                    r_lo  <= w_lo_fix;
                    r_dbz <= r_is_div & r_b_zero;
                end
                default: begin
                    r_cnt <= 6'd0;
                end
            endcase
        end
    end

    // Registered status outputs derived from the FSM only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= (r_state == ST_FIX);
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
endmodule
